// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial add/subtract stage.
// State encodings match the legacy control-unit header values.
package serial_adder_pkg;

    localparam int unsigned SA_STATE_W = 2;

    localparam logic [SA_STATE_W-1:0] SA_IDLE = 2'b00;
    localparam logic [SA_STATE_W-1:0] SA_RUN  = 2'b01;
    localparam logic [SA_STATE_W-1:0] SA_FIN  = 2'b10;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell shared across the datapath.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic CI,
    output logic SO,
    output logic CO
);

    assign SO = A ^ B ^ CI;
    assign CO = (A & B) | (CI & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: one operand bit per clock through a full_adder,
// with a START/BUSY/DONE handshake toward the control unit.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] OP_A,
    input  logic [WIDTH-1:0] OP_B,
    input  logic             CIN,
    input  logic             SUB,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic [SA_STATE_W-1:0] r_state;
    logic [SA_STATE_W-1:0] w_state_nxt;

    logic [WIDTH-1:0]      r_a_sh;
    logic [WIDTH-1:0]      r_b_sh;
    logic [WIDTH-1:0]      r_r_sh;
    logic                  r_carry;
    logic [CNT_W-1:0]      r_cnt;

    logic                  r_busy;
    logic                  r_done;
    logic [WIDTH-1:0]      r_sum;
    logic                  r_cout;
    logic                  r_ovf;

    logic                  w_last;
    logic                  w_so;
    logic                  w_co;

    full_adder u_fa (
        .A  (r_a_sh[0]),
        .B  (r_b_sh[0]),
        .CI (r_carry),
        .SO (w_so),
        .CO (w_co)
    );

    assign w_last = (r_state == SA_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= SA_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SA_IDLE: if (START) w_state_nxt = SA_RUN;
            SA_RUN:  if (w_last) w_state_nxt = SA_FIN;
            SA_FIN:  w_state_nxt = SA_IDLE;
            default: w_state_nxt = SA_IDLE;
        endcase
    end

    // Handshake flags follow the state being entered
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == SA_RUN);
            r_done <= (w_state_nxt == SA_FIN);
        end
    end

    // Operand capture, serial shift and result latch
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_r_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                SA_IDLE: begin
                    if (START) begin
                        r_a_sh  <= OP_A;
                        r_b_sh  <= SUB ? ~OP_B : OP_B;
                        r_carry <= SUB | CIN;
                        r_cnt   <= '0;
                    end
                end
                SA_RUN: begin
                    r_r_sh  <= {w_so, r_r_sh[WIDTH-1:1]};
                    r_carry <= w_co;
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    // Final bit: carry-in of this step is the carry into the MSB
                    if (w_last) begin
                        r_sum  <= {w_so, r_r_sh[WIDTH-1:1]};
                        r_cout <= w_co;
                        r_ovf  <= r_carry ^ w_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY = r_busy;
    assign DONE = r_done;
    assign SUM  = r_sum;
    assign COUT = r_cout;
    assign OVF  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8: vector table plus handshake corner cases.
module tb_serial_adder;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .START (start),
        .OP_A  (op_a),
        .OP_B  (op_b),
        .CIN   (cin),
        .SUB   (sub),
        .BUSY  (busy),
        .DONE  (done),
        .SUM   (sum),
        .COUT  (cout),
        .OVF   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] exp_sum;
        logic       exp_cout;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation; optionally re-pulse START with other operands at cycle repulse_j
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic sb, input logic [7:0] es, input logic ec,
                          input logic eo, input int repulse_j);
        int busy_n;
        int done_j;
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        cin   = ci;
        sub   = sb;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op_a  = ~a;
        op_b  = 8'($urandom);
        cin   = ~ci;
        sub   = ~sb;
        busy_n = 0;
        done_j = -1;
        for (int j = 0; j < 40; j++) begin
            if (j > 0) @(negedge clk);
            if (j == repulse_j) begin
                start = 1'b1;
                op_a  = 8'hAA;
                op_b  = 8'h11;
            end else if (j == repulse_j + 1) begin
                start = 1'b0;
            end
            if (done) begin
                done_j = j;
                break;
            end
            if (busy) busy_n++;
        end
        check("busy_cycles", busy_n, WIDTH);
        check("done_cycle", done_j, WIDTH);
        check("sum", int'(sum), int'(es));
        check("cout", int'(cout), int'(ec));
        check("ovf", int'(ovf), int'(eo));
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("busy_after_fin", int'(busy), 0);
    endtask

    initial begin
        int t_first;
        int t_second;
        int n_done;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[4] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[6] = '{8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[7] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[8] = '{8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[9] = '{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        op_a  = 8'h00;
        op_b  = 8'h00;
        cin   = 1'b0;
        sub   = 1'b0;
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_sum", int'(sum), 0);
        check("rst_cout", int'(cout), 0);
        check("rst_ovf", int'(ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                   vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf, -1);
        end

        // START re-pulsed mid-operation is ignored
        run_op(8'h21, 8'h43, 1'b0, 1'b0, 8'h64, 1'b0, 1'b0, 3);
        repeat (3) @(negedge clk);
        check("repulse_not_queued", int'(busy), 0);

        // Back-to-back with START held high
        @(negedge clk);
        op_a  = 8'h0F;
        op_b  = 8'h01;
        cin   = 1'b0;
        sub   = 1'b0;
        start = 1'b1;
        n_done   = 0;
        t_first  = -1;
        t_second = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (n_done == 1) t_first = c;
                else begin
                    t_second = c;
                    start = 1'b0;
                    break;
                end
            end
        end
        check("held_second_done", n_done, 2);
        check("held_spacing", t_second - t_first, WIDTH + 2);
        check("held_sum", int'(sum), 8'h10);

        // Idle hold: results stable, no DONE, while operands wander
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            op_a = 8'($urandom);
            op_b = 8'($urandom);
            check("idle_sum", int'(sum), 8'h10);
            check("idle_done", int'(done), 0);
        end

        // Asynchronous reset mid-operation
        @(negedge clk);
        op_a  = 8'h12;
        op_b  = 8'h34;
        cin   = 1'b0;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_sum", int'(sum), 0);
        check("abort_cout", int'(cout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
